// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU width constants
package fpu_pkg;

  // Significand width including the hidden bit
  localparam int N      = 24;
  // Fraction field width as seen by the multiply path
  localparam int FRAC_W = N - 1;
  // Registered product width; the top bit is always zero
  localparam int PROD_W = 2 * N - 1;

endpackage

// File: rtl/pp_adder_row.sv
// rtl/pp_adder_row.sv - carry-save row, one 3:2 compressor per bit
module pp_adder_row #(
  parameter int W = 47
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Per-bit sum; carry is the per-bit majority moved up one weight.
  // The majority of the top bit would land at weight 2^W and is dropped,
  // so sum + carry equals a + b + c modulo 2^W.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};
  end

endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - registered unsigned fraction multiplier, carry-save array
module multiplier #(
  parameter int N = fpu_pkg::N
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N-2:0]     frac1,
  input  logic [N-2:0]     frac2,
  output logic [2*N-2:0]   R
);

  localparam int FW = N - 1;
  localparam int PW = 2 * N - 1;

  logic [PW-1:0] pp [FW];
  logic [PW-1:0] product;

  // Partial product rows: frac1 gated by one multiplier bit, shifted to its weight
  for (genvar i = 0; i < FW; i++) begin : g_pp
    assign pp[i] = ({PW{frac2[i]}} & {{(PW-FW){1'b0}}, frac1}) << i;
  end

  // Linear carry-save chain: each stage folds one more row into the (sum, carry) pair.
  // The product is below 2^(PW-1), so working modulo 2^PW loses nothing.
  for (genvar i = 0; i < FW - 1; i++) begin : g_red
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    if (i == 0) begin : g_first
      assign s = pp[0];
      assign c = pp[1];
    end else begin : g_row
      pp_adder_row #(.W(PW)) u_row (
        .a     (g_red[i-1].s),
        .b     (g_red[i-1].c),
        .c     (pp[i+1]),
        .sum   (s),
        .carry (c)
      );
    end
  end

  // Final carry-propagate add merges the redundant pair
  assign product = g_red[FW-2].s + g_red[FW-2].c;

  // Output register: cleared asynchronously, otherwise loads the product every edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      R <= '0;
    end else begin
      R <= product;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - self-checking bench for multiplier
module tb_multiplier;

  localparam int FW = fpu_pkg::FRAC_W;
  localparam int PW = fpu_pkg::PROD_W;

  logic          clk;
  logic          rstn;
  logic [FW-1:0] frac1;
  logic [FW-1:0] frac2;
  logic [PW-1:0] R;

  int vectors;
  int miscompares;
  logic [PW-1:0] last_exp;

  multiplier dut (
    .clk   (clk),
    .rstn  (rstn),
    .frac1 (frac1),
    .frac2 (frac2),
    .R     (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] ref_mul(input logic [FW-1:0] a, input logic [FW-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    return p[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a pair between edges, confirm R has not moved yet, then confirm it after the edge
  task automatic apply(input string tag, input logic [FW-1:0] a, input logic [FW-1:0] b);
    @(negedge clk);
    frac1 = a;
    frac2 = b;
    #1;
    check({tag, "_hold"}, R, last_exp);
    @(posedge clk);
    #1;
    last_exp = ref_mul(a, b);
    check(tag, R, last_exp);
    check({tag, "_msb"}, {46'd0, R[PW-1]}, '0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rstn  = 1'b0;
    frac1 = 23'd7;
    frac2 = 23'd3;

    // Reset held across several edges
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset", R, '0);
    end

    // Release: first edge loads 7*3, then stays stable
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    last_exp = ref_mul(23'd7, 23'd3);
    check("release", R, 47'd21);
    for (int k = 0; k < 10; k++) begin
      #15;
      check("stable", R, 47'd21);
    end

    // Boundary operands
    apply("max", 23'h7FFFFF, 23'h7FFFFF);
    check("max_const", R, 47'h3FFFFF000001);
    apply("ident", 23'd1, 23'h5A5A5A);
    check("ident_const", R, 47'h5A5A5A);
    apply("zero", 23'd0, 23'h5A5A5A);
    check("zero_const", R, '0);

    // Back-to-back stream
    apply("s0", 23'd2, 23'd3);
    check("s0_const", R, 47'd6);
    apply("s1", 23'h400000, 23'd2);
    check("s1_const", R, 47'h800000);
    apply("s2", 23'h123456, 23'h10);
    check("s2_const", R, 47'h1234560);

    // Randomized stream, with edge values mixed in
    for (int k = 0; k < 200; k++) begin
      logic [FW-1:0] a;
      logic [FW-1:0] b;
      a = FW'($urandom);
      b = FW'($urandom);
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '1;
      if ($urandom_range(0, 15) == 0) b = FW'(1) << $urandom_range(0, FW - 1);
      apply("rand", a, b);
    end

    // Mid-stream reset: clears at once, holds across an edge, resumes on release
    apply("pre_rst", 23'h7ABCDE, 23'h654321);
    #2;
    rstn = 1'b0;
    #1;
    check("async_clear", R, '0);
    @(posedge clk);
    #1;
    check("rst_hold", R, '0);
    @(negedge clk);
    frac1 = 23'h0F0F0F;
    frac2 = 23'h33;
    rstn  = 1'b1;
    #1;
    check("rst_rel_hold", R, '0);
    @(posedge clk);
    #1;
    last_exp = ref_mul(23'h0F0F0F, 23'h33);
    check("rst_resume", R, last_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
